// File: rtl/instr_pkg.sv
// Shared field layout for the coprocessor instruction word, used by both the
// host-side encoder and the coprocessor decoder.
// Optional build macro INSTR_PARITY_EN: when defined, bit 31 carries even
// parity over bits 30:0; otherwise bit 31 is always zero.
package instr_pkg;

   localparam int INSTR_W         = 32;

   localparam int OPC_LSB         = 0;
   localparam int OPC_W           = 4;
   localparam int LOC_LSB         = 4;
   localparam int LOC_W           = 6;
   localparam int ID_LSB          = 10;
   localparam int ID_W            = 2;
   localparam int DATA_NARROW_LSB = 12;
   localparam int DATA_WIDE_LSB   = 4;
   localparam int DATA_W          = 16;

   localparam int OPC_WIDE_BIT    = 3;
   localparam int PARITY_BIT      = 31;

   typedef logic [INSTR_W-1:0] instr_t;

   // Packs one field set into an instruction word. The wide format drops the
   // id/location fields and moves the data down next to the opcode.
   function automatic instr_t pack_instr(
      input logic [OPC_W-1:0]  opcode,
      input logic [ID_W-1:0]   id,
      input logic [LOC_W-1:0]  location,
      input logic [DATA_W-1:0] data
   );
      instr_t word;
      word = '0;
      word[OPC_LSB +: OPC_W] = opcode;
      if (opcode[OPC_WIDE_BIT]) begin
         word[DATA_WIDE_LSB +: DATA_W] = data;
      end else begin
         word[LOC_LSB +: LOC_W]           = location;
         word[ID_LSB +: ID_W]             = id;
         word[DATA_NARROW_LSB +: DATA_W]  = data;
      end
`ifdef INSTR_PARITY_EN
      word[PARITY_BIT] = ^word[PARITY_BIT-1:0];
`endif
      return word;
   endfunction

endpackage

// File: rtl/instr_fifo.sv
// Generic first-word-fall-through FIFO of packed instruction words with
// occupancy level, full/empty flags and a synchronous flush.
module instr_fifo
   import instr_pkg::*;
#(
   parameter int  DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  instr_t       wr_data,
   input  logic         pop,
   output instr_t       rd_data,
   output logic [AW:0]  level,
   output logic         full,
   output logic         empty
);

   localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   instr_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q,  level_d;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (level_q == LVL_FULL);
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign rd_data = mem[rd_ptr_q];
   assign push_ok = push && !full && !flush;
   assign pop_ok  = pop && !empty && !flush;

   // Next pointer/level: flush wins over any transfer; pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
         endcase
      end
   end

   // Pointer and level registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: rtl/instr_encoder.sv
// Host-side instruction encoder: packs field sets into 32-bit coprocessor
// words, queues them in an FWFT FIFO and issues them downstream.
// Optional build macro INSTR_PARITY_EN (see instr_pkg) adds a parity bit.
module instr_encoder
   import instr_pkg::*;
#(
   parameter int  DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [3:0]   in_opcode,
   input  logic [1:0]   in_id,
   input  logic [5:0]   in_location,
   input  logic [15:0]  in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [31:0]  out_instr,
   output logic [AW:0]  level,
   output logic         overflow,
   output logic [15:0]  issue_count
);

   instr_t       packed_word;
   instr_t       head_word;
   logic         fifo_full;
   logic         fifo_empty;
   logic         overflow_q,    overflow_d;
   logic [15:0]  issue_count_q, issue_count_d;

   assign packed_word = pack_instr(in_opcode, in_id, in_location, in_data);
   assign in_ready    = !fifo_full;
   assign out_valid   = !fifo_empty;
   assign out_instr   = out_valid ? head_word : '0;
   assign overflow    = overflow_q;
   assign issue_count = issue_count_q;

   instr_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .push    (in_valid),
      .wr_data (packed_word),
      .pop     (out_ready),
      .rd_data (head_word),
      .level   (level),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Sticky overflow and issued-word counter; a flush cancels the pop too.
   always_comb begin
      overflow_d    = overflow_q;
      issue_count_d = issue_count_q;
      if (flush) begin
         overflow_d = 1'b0;
      end else begin
         if (in_valid && !in_ready) overflow_d = 1'b1;
         if (out_valid && out_ready) issue_count_d = issue_count_q + 16'd1;
      end
   end

   // Status registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q    <= 1'b0;
         issue_count_q <= '0;
      end else begin
         overflow_q    <= overflow_d;
         issue_count_q <= issue_count_d;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a queue scoreboard holds the words
// expected at the output, filled as field sets are accepted and drained as
// the coprocessor side takes them.
module tb_instr_encoder;

   localparam int DEPTH = 4;
   localparam int AW    = 2;

`ifdef INSTR_PARITY_EN
   localparam logic [31:0] NARROW_EXP = 32'h8ABCD4B2;
   localparam logic [31:0] WIDE_EXP   = 32'h80012349;
`else
   localparam logic [31:0] NARROW_EXP = 32'h0ABCD4B2;
   localparam logic [31:0] WIDE_EXP   = 32'h00012349;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   in_opcode;
   logic [1:0]   in_id;
   logic [5:0]   in_location;
   logic [15:0]  in_data;
   logic         out_valid;
   logic         out_ready;
   logic [31:0]  out_instr;
   logic [AW:0]  level;
   logic         overflow;
   logic [15:0]  issue_count;

   int           checks = 0;
   int           errors = 0;
   logic [31:0]  sb [$];
   logic         m_ovf;
   logic [15:0]  m_count;

   instr_encoder #(
      .DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_opcode   (in_opcode),
      .in_id       (in_id),
      .in_location (in_location),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .level       (level),
      .overflow    (overflow),
      .issue_count (issue_count)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Reference packing written straight from the word layout.
   function automatic logic [31:0] model_pack(input logic [3:0] opc, input logic [1:0] id,
                                             input logic [5:0] loc, input logic [15:0] data);
      logic [31:0] w;
      if (opc[3]) w = {12'b0, data, opc};
      else        w = {4'b0, data, id, loc, opc};
`ifdef INSTR_PARITY_EN
      w[31] = ^w[30:0];
`endif
      return w;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Compares every output against the scoreboard/model state.
   task automatic checkOutput();
      chk("out_valid",   32'(out_valid),   32'(sb.size() != 0));
      chk("out_instr",   out_instr,        (sb.size() != 0) ? sb[0] : 32'h0);
      chk("in_ready",    32'(in_ready),    32'(sb.size() != DEPTH));
      chk("level",       32'(level),       32'(sb.size()));
      chk("overflow",    32'(overflow),    32'(m_ovf));
      chk("issue_count", 32'(issue_count), 32'(m_count));
   endtask

   // Drives one cycle of inputs, checks pre-edge outputs, advances the model.
   task automatic applyStimulus(input logic v, input logic [3:0] opc, input logic [1:0] id,
                                input logic [5:0] loc, input logic [15:0] data,
                                input logic ordy, input logic fl);
      logic do_push;
      logic do_pop;
      in_valid    = v;
      in_opcode   = opc;
      in_id       = id;
      in_location = loc;
      in_data     = data;
      out_ready   = ordy;
      flush       = fl;
      #1;
      checkOutput();
      if (fl) begin
         sb.delete();
         m_ovf = 1'b0;
      end else begin
         do_push = v && (sb.size() != DEPTH);
         do_pop  = ordy && (sb.size() != 0);
         if (v && sb.size() == DEPTH) m_ovf = 1'b1;
         if (do_pop) begin
            void'(sb.pop_front());
            m_count++;
         end
         if (do_push) sb.push_back(model_pack(opc, id, loc, data));
      end
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input logic ordy);
      applyStimulus(1'b0, 4'h0, 2'h0, 6'h0, 16'h0, ordy, 1'b0);
   endtask

   initial begin
      m_ovf       = 1'b0;
      m_count     = '0;
      rst_n       = 1'b0;
      flush       = 1'b0;
      in_valid    = 1'b0;
      in_opcode   = '0;
      in_id       = '0;
      in_location = '0;
      in_data     = '0;
      out_ready   = 1'b0;

      // Reset state.
      #12;
      checkOutput();
      rst_n = 1'b1;
      @(posedge clk);
      #2;

      // Narrow pack into an empty FIFO, then issue it.
      $display("[TB] narrow pack");
      applyStimulus(1'b1, 4'd2, 2'd1, 6'h0B, 16'hABCD, 1'b0, 1'b0);
      chk("narrow_word", out_instr, NARROW_EXP);
      idle(1'b1);

      // Wide pack: id/location must not appear.
      $display("[TB] wide pack");
      applyStimulus(1'b1, 4'd9, 2'd3, 6'h3F, 16'h1234, 1'b0, 1'b0);
      chk("wide_word", out_instr, WIDE_EXP);
      idle(1'b1);

      // Fill with the consumer stalled; 5th attempt overflows and is held.
      $display("[TB] fill and stall");
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b1, 4'(i), 2'(i), 6'(i * 5), 16'(16'h1000 + i), 1'b0, 1'b0);
      chk("fill_overflow", 32'(overflow), 32'h1);
      // Full with a pop: the held set must not enter this cycle.
      applyStimulus(1'b1, 4'd4, 2'd0, 6'd20, 16'h1004, 1'b1, 1'b0);
      applyStimulus(1'b1, 4'd4, 2'd0, 6'd20, 16'h1004, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) idle(1'b1);
      chk("fill_drained_count", 32'(issue_count), 32'd7);

      // Concurrent push and pop holding level at 2.
      $display("[TB] push+pop at level 2");
      applyStimulus(1'b1, 4'hA, 2'd0, 6'd0, 16'h5555, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'h3, 2'd2, 6'h15, 16'h6666, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++)
         applyStimulus(1'b1, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                       6'($urandom_range(0, 63)), 16'($urandom_range(0, 65535)), 1'b1, 1'b0);
      chk("steady_level", 32'(level), 32'd2);
      chk("steady_count", 32'(issue_count), 32'd17);

      // Flush at level 3 with overflow still set and a push offered.
      $display("[TB] flush");
      applyStimulus(1'b1, 4'h1, 2'd1, 6'h01, 16'h7777, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'hF, 2'd3, 6'h3F, 16'hFFFF, 1'b1, 1'b1);
      chk("flush_level", 32'(level), 32'd0);
      chk("flush_overflow", 32'(overflow), 32'd0);
      idle(1'b0);

      // Asynchronous reset between edges with words pending.
      $display("[TB] async reset mid-stream");
      applyStimulus(1'b1, 4'h2, 2'd0, 6'h02, 16'h0102, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'h8, 2'd0, 6'h00, 16'h0304, 1'b0, 1'b0);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("rst_out_valid",   32'(out_valid),   32'd0);
      chk("rst_out_instr",   out_instr,        32'd0);
      chk("rst_issue_count", 32'(issue_count), 32'd0);
      chk("rst_level",       32'(level),       32'd0);
      chk("rst_in_ready",    32'(in_ready),    32'd1);
      sb.delete();
      m_ovf   = 1'b0;
      m_count = '0;
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #2;
      applyStimulus(1'b1, 4'd2, 2'd1, 6'h0B, 16'hABCD, 1'b0, 1'b0);
      chk("post_rst_word", out_instr, NARROW_EXP);
      idle(1'b1);
      idle(1'b1);
      chk("post_rst_count", 32'(issue_count), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Host-side counterpart of the coprocessor instruction decoder.
- Accepts instruction fields (opcode, matrix id, element location, 16-bit data) over a valid/ready handshake and packs them into the 32-bit coprocessor instruction word.
- Buffers packed words in a small FIFO and issues them to the coprocessor over a second valid/ready handshake.
- Tracks issued-instruction count and input overflow.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, ≥2.
- AW, $clog2(DEPTH), FIFO pointer width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of FIFO, level and overflow flag.
- in_valid  in  1  field set valid.
- in_ready  out  1  encoder can accept a field set (= !full).
- in_opcode  in  4  opcode; bit 3 selects the wide-data format.
- in_id  in  2  matrix id.
- in_location  in  6  element location code, passed through unmodified.
- in_data  in  16  immediate/element data.
- out_valid  out  1  out_instr holds a valid instruction.
- out_ready  in  1  coprocessor accepts the instruction.
- out_instr  out  32  packed instruction word.
- level  out  AW+1  current FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky: in_valid seen while in_ready low.
- issue_count  out  16  number of completed output handshakes, wraps.

Behaviour:
- Packing, combinational at the input:
  - in_opcode[3]=1: instr = {12'b0, in_data, in_opcode}; in_id and in_location ignored.
  - in_opcode[3]=0: instr = {4'b0, in_data, in_id, in_location, in_opcode}, i.e. data[27:12], id[11:10], location[9:4], opcode[3:0].
- Push: in_valid && in_ready at a rising edge writes the packed word at the write pointer; write pointer and level increment.
- Pop: out_valid && out_ready at a rising edge; read pointer increments; level and issue_count decrement/increment respectively.
- FIFO is first-word-fall-through:
  - out_valid = (level != 0).
  - out_instr = head word when out_valid, else 32'h0.
- Latency: a word pushed at edge N is visible on out_* in the cycle after edge N (1 cycle). No combinational input→output bypass.
- Simultaneous push and pop, level strictly between 0 and DEPTH: both occur, level unchanged.
- Full (level == DEPTH): in_ready=0; no push even if a pop happens in the same cycle.
- Empty: pop impossible (out_valid=0); a push in the same cycle makes out_valid=1 the next cycle.
- Pointers wrap modulo DEPTH; issue_count wraps 16'hFFFF→0.
- Overflow: in_valid && !in_ready sets overflow; it stays set until flush or reset. The field set is not stored and the upstream must hold it.
- flush=1: next edge sets pointers=0, level=0, overflow=0; push/pop in the same cycle are ignored; issue_count retained.
- Reset (rst_n=0, asynchronous): pointers, level, overflow, issue_count = 0; out_valid=0, out_instr=0, in_ready=1. FIFO memory need not be cleared.
- Reset asserted mid-transfer: all pending words are discarded; no partial word is issued after release.

Optional Feature:
- Macro INSTR_PARITY_EN.
  - Defined: out_instr[31] = ^out_instr[30:0] (even parity over the whole word), computed at pack time and stored in the FIFO.
  - Undefined: bit 31 is always 0. Packing is otherwise identical.

Decomposition:
- Package instr_pkg:
  - Field LSB/width constants: OPC 0/4, LOC 4/6, ID 10/2, DATA_NARROW 12/16, DATA_WIDE 4/16.
  - OPC_WIDE_BIT=3.
  - A packed-instruction typedef.
  - Shared with the decoder.
- Sub-module instr_fifo: generic DEPTH×32 FWFT synchronous FIFO with level/full/empty and flush. Packing, overflow and counting remain in the top module.

Test Plan:
- Narrow pack: opcode=2, id=1, location=6'h0B, data=16'hABCD, push into empty FIFO -> next cycle out_valid=1, out_instr=32'h0ABCD4B2 (32'h8ABCD4B2 with INSTR_PARITY_EN).
- Wide pack: opcode=9, data=16'h1234, id=3, location=6'h3F -> out_instr=32'h00012349 (32'h80012349 with parity); id/location bits absent.
- Fill/stall: out_ready=0, push 5 words with DEPTH=4 -> level=4, in_ready=0 after the 4th push, overflow=1 on the 5th attempt; release out_ready -> 4 words issued in push order, issue_count=4.
- Simultaneous push+pop at level=2 for 10 cycles -> level stays 2, ordering preserved, issue_count +10.
- Flush with level=3 and overflow=1, push asserted the same cycle -> next cycle level=0, out_valid=0, overflow=0, pushed word not stored.
- Async reset mid-stream (rst_n low between edges) -> out_valid=0 and out_instr=0 immediately; issue_count=0; after release, first pushed word is issued correctly.
